ibus_dbus_arbiter: RTL
======================

# ibus_dbus_arbiter

Two-to-one bus arbiter sitting directly downstream of `core`: consumes the core's instruction-bus request (`ireq`/`iresp`) and data-bus request (`dreq`/`dresp`) and serialises them onto the single memory-side bus (`oreq`/`oresp`). Grants one single-beat transaction at a time, latches the winning request, and returns `addr_ok`/`data_ok` plus read data to the granted port only. Data-bus priority by default; round-robin is a compile option.

## Interface
Parameters:
- none (widths fixed by shared package types)

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — asynchronous, active-low reset.
- `ireq` in `ibus_req_t` — `valid`, 64-bit `addr`.
- `iresp` out `ibus_resp_t` — `addr_ok`, `data_ok`, 32-bit `data`.
- `dreq` in `dbus_req_t` — `valid`, 64-bit `addr`, `size` (`msize_t`), 8-bit `strobe`, 64-bit `data`.
- `dresp` out `dbus_resp_t` — `addr_ok`, `data_ok`, 64-bit `data`.
- `oreq` out `cbus_req_t` — `valid`, `is_write`, `size`, 64-bit `addr`, 8-bit `strobe`, 64-bit `data`, `len` (always `MLEN1`).
- `oresp` in `cbus_resp_t` — `ready`, `last`, 64-bit `data`.

## Operation
- FSM states: `IDLE`, `IBUS`, `DBUS`. Reset state `IDLE`.
- `IDLE`: if `dreq.valid` → latch `dreq` into `req_q`, next `DBUS`; else if `ireq.valid` → latch ireq (`is_write=0`, `size=MSIZE4`, `strobe=0`), next `IBUS`; else stay.
- `is_write` for data requests = `|dreq.strobe`.
- `IBUS`/`DBUS`: `oreq` driven from `req_q` with `valid=1`; held stable until completion.
- Completion = `oresp.ready && oresp.last`. Same cycle: granted port gets `addr_ok=1`, `data_ok=1`; next state `IDLE`.
- `iresp.data` = `oresp.data[63:32]` if latched `addr[2]`, else `oresp.data[31:0]`. `dresp.data` = `oresp.data` unmodified.
- Non-granted port: `addr_ok=0`, `data_ok=0`, `data=0`.
- Requesters hold `valid` and payload until `data_ok`; changes after latch are ignored (response belongs to latched request).
- Request deasserted before grant: not served, no response.
- `oresp.ready` without `last`: ignored (single-beat only); no completion.

## Timing
- Reset values: `oreq` all-zero; `iresp`, `dresp` all-zero; state `IDLE`; `req_q` zero; last-grant flag zero.
- Reset assertion mid-transaction: immediate return to `IDLE`, `oreq.valid` drops asynchronously, transaction abandoned, no `data_ok`.
- Cycle 0: request seen in `IDLE`. Cycle 1: `oreq.valid=1`. Memory `ready&&last` in cycle k≥1 → `data_ok` in cycle k (combinational from `oresp`). Cycle k+1: `IDLE`, next grant decided; `oreq.valid` at k+2.
- Minimum round trip 2 cycles; one idle bubble between back-to-back transactions.
- `data_ok` is a one-cycle pulse per granted transaction.
- Simultaneous `ireq.valid` and `dreq.valid` in `IDLE`: data wins (default build).

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: 1-bit last-grant flag (0=ibus, 1=dbus) updated at each grant; on simultaneous requests grant the port not granted last; single requester always granted.
- Undefined: fixed data-over-instruction priority; flag absent.

## Structure
- Shared package `pipes`: `arb_state_t` enum (`IDLE`, `IBUS`, `DBUS`), `arb_req_t` latched-request struct (`is_write`, `size`, `addr`, `strobe`, `data`, `is_ibus`). Bus types `ibus_*`, `dbus_*`, `cbus_*`, `msize_t`, `MLEN1` stay in `common`.
- One sub-module: `arb_select` — combinational pick from (`ivalid`, `dvalid`, last-grant) → grant vector; both priority modes live there.

## Test plan
- Lone ibus read addr `0x8000_0004`, memory ready in cycle 1 with data `0x1111_2222_3333_4444` → `iresp.data_ok` cycle 1, `data=0x1111_2222`; `dresp` stays zero.
- Both valid in `IDLE` (default build), ibus `0x8000_0000`, dbus read `0x8000_1000` → dbus granted first, ibus served afterward after one idle cycle.
- Same stimulus with `ARB_ROUND_ROBIN_EN`, both held valid for 4 transactions → grants alternate D, I, D, I.
- dbus write `addr=0x8000_2000`, `strobe=0x0F`, `data=0xDEAD_BEEF`, memory ready after 3 wait cycles → `oreq.is_write=1`, fields stable 4 cycles, `dresp.data_ok` only in ready cycle.
- Reset pulled low while in `DBUS` awaiting ready → `oreq.valid=0` immediately, state `IDLE`, no `data_ok` after release.
- `oresp.ready=1`, `last=0` for 2 cycles then `last=1` → only final cycle produces `data_ok`.

Source files
------------

// File: rtl/ibus_dbus_arbiter_pkg.sv
// rtl/ibus_dbus_arbiter_pkg.sv - shared bus types (common) and arbiter-private types (pipes)
package common;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
        mlen_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;
endpackage

package pipes;
    import common::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
        logic    is_ibus;
    } arb_req_t;

    localparam int GRANT_I = 0;
    localparam int GRANT_D = 1;
endpackage

// File: rtl/ibus_dbus_arbiter_if.sv
// rtl/ibus_dbus_arbiter_if.sv - core-side and memory-side buses of the arbiter
interface ibus_dbus_arbiter_if;
    import common::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave  (input ireq, dreq, oresp, output iresp, dresp, oreq);
    modport master (output ireq, dreq, oresp, input iresp, dresp, oreq);
endinterface

// File: rtl/ibus_dbus_arbiter_select.sv
// rtl/ibus_dbus_arbiter_select.sv - grant pick; ARB_ROUND_ROBIN_EN selects round-robin over data priority
module arb_select
    import pipes::*;
(
    input  logic       ivalid,
    input  logic       dvalid,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       last_grant,
`endif
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        // last_grant: 0 = ibus, 1 = dbus; a tie goes to the other port
        if (ivalid && dvalid) begin
            if (last_grant) grant[GRANT_I] = 1'b1;
            else            grant[GRANT_D] = 1'b1;
        end else if (dvalid) begin
            grant[GRANT_D] = 1'b1;
        end else if (ivalid) begin
            grant[GRANT_I] = 1'b1;
        end
`else
        if (dvalid)      grant[GRANT_D] = 1'b1;
        else if (ivalid) grant[GRANT_I] = 1'b1;
`endif
    end
endmodule

// File: rtl/ibus_dbus_arbiter.sv
// rtl/ibus_dbus_arbiter.sv - serialises ibus/dbus single-beat requests onto one memory bus; ARB_ROUND_ROBIN_EN enables round-robin
module ibus_dbus_arbiter
    import common::*;
    import pipes::*;
(
    input  logic               clk,
    input  logic               reset,
    ibus_dbus_arbiter_if.slave bus
);
    arb_state_t state_q, state_d;
    arb_req_t   req_q, req_d;
    logic [1:0] grant;
    logic       done;
`ifdef ARB_ROUND_ROBIN_EN
    logic       last_grant_q, last_grant_d;
`endif

    arb_select u_select (
        .ivalid     (bus.ireq.valid),
        .dvalid     (bus.dreq.valid),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant_q),
`endif
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        bus.oreq  = '0;
        bus.iresp = '0;
        bus.dresp = '0;
        done      = bus.oresp.ready && bus.oresp.last;

        case (state_q)
            IDLE: begin
                if (grant[GRANT_D]) begin
                    req_d.is_write = |bus.dreq.strobe;
                    req_d.size     = bus.dreq.size;
                    req_d.addr     = bus.dreq.addr;
                    req_d.strobe   = bus.dreq.strobe;
                    req_d.data     = bus.dreq.data;
                    req_d.is_ibus  = 1'b0;
                    state_d        = DBUS;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d   = 1'b1;
`endif
                end else if (grant[GRANT_I]) begin
                    req_d.is_write = 1'b0;
                    req_d.size     = MSIZE4;
                    req_d.addr     = bus.ireq.addr;
                    req_d.strobe   = '0;
                    req_d.data     = '0;
                    req_d.is_ibus  = 1'b1;
                    state_d        = IBUS;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d   = 1'b0;
`endif
                end
            end
            IBUS, DBUS: begin
                // Memory side sees only the latched copy, so requester changes are ignored
                bus.oreq.valid    = 1'b1;
                bus.oreq.is_write = req_q.is_write;
                bus.oreq.size     = req_q.size;
                bus.oreq.addr     = req_q.addr;
                bus.oreq.strobe   = req_q.strobe;
                bus.oreq.data     = req_q.data;
                bus.oreq.len      = MLEN1;
                if (req_q.is_ibus) begin
                    bus.iresp.data    = req_q.addr[2] ? bus.oresp.data[63:32] : bus.oresp.data[31:0];
                    bus.iresp.addr_ok = done;
                    bus.iresp.data_ok = done;
                end else begin
                    bus.dresp.data    = bus.oresp.data;
                    bus.dresp.addr_ok = done;
                    bus.dresp.data_ok = done;
                end
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
